lacc_reg_file: RTL and testbench
================================

Name: lacc_reg_file

Overview:
- 16-entry x 16-bit register file for the lacc datapath.
- Two combinational read ports (Data1/Data2) serve ALU operands.
- A third dedicated read port (Data3) continuously exposes the accumulator register, index 1.
- The lacc ("load accumulator") operation writes WriteData to WriteReg with WriteReg driven from the constant accumulator index; Data3 then reflects the loaded value.

Parameters:
- DATA_W, 16, width of each register and data port.
- ADDR_W, 4, register index width; depth = 2**ADDR_W = 16.
- ACC_IDX, 1, register index exposed on Data3 (accumulator).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Read1  in  ADDR_W  index for Data1.
- Read2  in  ADDR_W  index for Data2.
- WriteReg  in  ADDR_W  index written when RegWrite=1.
- WriteData  in  DATA_W  value written.
- RegWrite  in  1  write enable.
- Data1  out  DATA_W  contents of register Read1.
- Data2  out  DATA_W  contents of register Read2.
- Data3  out  DATA_W  contents of register ACC_IDX (accumulator).
- AccIdx  out  ADDR_W  constant ACC_IDX; the lacc datapath ties this to WriteReg.

Behaviour:
- Reset: reset_n=0 asynchronously clears all 16 registers to 0x0000, independent of clock.
- Outputs during and after reset: Data1, Data2 and Data3 read 0x0000.
- Write: on rising clock edge with reset_n=1 and RegWrite=1, reg[WriteReg] <= WriteData.
  - RegWrite=0: no register changes.
- Register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0x0000.
- Reads are combinational (zero latency) from current register contents.
- Read-during-write, same cycle: Data1/Data2/Data3 return the old value until the edge, and the new value immediately after it. This is one-edge write latency, no bypass unless the optional feature is enabled.
- Data3 always equals reg[ACC_IDX]; it updates right after any edge that writes ACC_IDX.
- Read1 = Read2 = the same index: both ports return the same value.
- Reset asserted mid-write (same edge): reset wins; the register stays 0.
- Reset released: the first write occurs at the first rising edge with reset_n=1.
- AccIdx is a pure constant (4'b0001 at default), unaffected by clock or reset.
- No X propagation: every index 0..15 is valid; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when RegWrite=1 and WriteReg!=0 matches a port's read index, that port (Data1, Data2, or Data3 for ACC_IDX) returns WriteData combinationally in the same cycle. Write-then-read needs zero cycles.
- Undefined: no forwarding; behaviour exactly as in Behaviour above.

Decomposition:
- Shared package lacc_pkg:
  - DATA_W, ADDR_W, ACC_IDX constants
  - typedef data_t (DATA_W bits)
  - typedef reg_idx_t (ADDR_W bits)
  - constant ZERO_IDX = 0
- One natural sub-module: reg_word — single DATA_W register with write enable, async active-low clear, clock and reset_n inputs. Instantiated 15 times (indices 1..15); index 0 is a constant.
- Write decode and read muxes stay in the top.

Test Plan:
- Reset: preload reg1=0x1234, assert reset_n=0 between edges -> Data3, Data1 (Read1=1) drop to 0x0000 immediately, without a clock edge.
- lacc sweep: WriteReg=AccIdx, RegWrite=1, WriteData=0..4 incremented each clock low phase, clock period 100 ns -> after each rising edge, Data3 equals the WriteData just applied (0,1,2,3,4).
- Zero register: write 0xFFFF to index 0 -> Data1 with Read1=0 reads 0x0000.
- Dual read: write reg5=0xA5A5, reg9=0x5A5A; Read1=5, Read2=9 -> Data1=0xA5A5, Data2=0x5A5A. RegWrite=0 with WriteData=0xDEAD to reg5 -> Data1 stays 0xA5A5.
- Read-during-write: Read1=3, reg3=0x0011, write 0x0022 -> Data1=0x0011 before the edge, 0x0022 after. With REGFILE_BYPASS_EN: 0x0022 before the edge.
- Reset collision: reset_n=0 coincident with a write of 0x7777 to reg1 -> Data3=0x0000 after the edge.

Source files
------------

// File: rtl/lacc_pkg.sv
// Shared constants and types for the lacc register file.
// Optional macro REGFILE_BYPASS_EN is consumed by lacc_reg_file.
package lacc_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int ACC_IDX = 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/reg_word.sv
// One register-file word: write-enabled flop with asynchronous active-low clear.
module reg_word
  import lacc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lacc_reg_file.sv
// 16x16 register file with two operand read ports and a fixed accumulator port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module lacc_reg_file #(
  parameter int DATA_W  = lacc_pkg::DATA_W,
  parameter int ADDR_W  = lacc_pkg::ADDR_W,
  parameter int ACC_IDX = lacc_pkg::ACC_IDX
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] Data3,
  output logic [ADDR_W-1:0] AccIdx
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:1]  wr_en;

  // Index 0 is a constant zero, so no storage exists for it.
  assign regs[0] = '0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_word
      assign wr_en[gi] = RegWrite && (WriteReg == ADDR_W'(gi));

      reg_word #(
        .WIDTH (DATA_W)
      ) u_word (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (wr_en[gi]),
        .d       (WriteData),
        .q       (regs[gi])
      );
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = RegWrite && (WriteReg != ADDR_W'(lacc_pkg::ZERO_IDX));

  always_comb begin
    Data1 = regs[Read1];
    Data2 = regs[Read2];
    Data3 = regs[ACC_IDX];
    if (fwd_ok && (WriteReg == Read1))               Data1 = WriteData;
    if (fwd_ok && (WriteReg == Read2))               Data2 = WriteData;
    if (fwd_ok && (WriteReg == ADDR_W'(ACC_IDX)))    Data3 = WriteData;
  end
`else
  always_comb begin
    Data1 = regs[Read1];
    Data2 = regs[Read2];
    Data3 = regs[ACC_IDX];
  end
`endif

  assign AccIdx = ADDR_W'(ACC_IDX);

endmodule

// File: tb/tb_lacc_reg_file.sv
// Randomized self-checking bench for lacc_reg_file against an array reference model.
module tb_lacc_reg_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  Read1, Read2, WriteReg;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [15:0] Data1, Data2, Data3;
  logic [3:0]  AccIdx;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [16];

  lacc_reg_file dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Data1     (Data1),
    .Data2     (Data2),
    .Data3     (Data3),
    .AccIdx    (AccIdx)
  );

  always #50 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%04h expected=%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mread(input logic [3:0] idx);
    return (idx == 4'd0) ? 16'h0000 : model[idx];
  endfunction

  // Value a read port should show before the edge of a pending write.
  function automatic logic [15:0] pre_read(input logic [3:0] idx);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteReg != 4'd0 && WriteReg == idx) return WriteData;
`endif
    return mread(idx);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  // One clock: drive at the falling edge, check before and after the rising edge.
  task automatic cycle(input logic wr, input logic [3:0] widx, input logic [15:0] wdata,
                       input logic [3:0] r1, input logic [3:0] r2, input string tag);
    @(negedge clock);
    RegWrite = wr; WriteReg = widx; WriteData = wdata; Read1 = r1; Read2 = r2;
    #1;
    check_eq({tag, "_pre_d1"}, Data1, pre_read(r1));
    check_eq({tag, "_pre_d2"}, Data2, pre_read(r2));
    check_eq({tag, "_pre_d3"}, Data3, pre_read(4'd1));
    @(posedge clock);
    if (wr && widx != 4'd0) model[widx] = wdata;
    #1;
    check_eq({tag, "_post_d1"}, Data1, mread(r1));
    check_eq({tag, "_post_d2"}, Data2, mread(r2));
    check_eq({tag, "_post_d3"}, Data3, mread(4'd1));
    $display("cycle %s: we=%0d wr=%0d wd=%04h r1=%0d d1=%04h r2=%0d d2=%04h d3=%04h",
             tag, wr, widx, wdata, r1, Data1, r2, Data2, Data3);
  endtask

  initial begin
    model_clear();
    reset_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0; Read1 = 4'd1; Read2 = 4'd7;
    #20;
    check_eq("rst_d1", Data1, 16'h0000);
    check_eq("rst_d2", Data2, 16'h0000);
    check_eq("rst_d3", Data3, 16'h0000);
    check_eq("acc_idx", {12'h000, AccIdx}, 16'h0001);
    @(negedge clock);
    reset_n = 1'b1;

    // Asynchronous reset between edges
    cycle(1'b1, 4'd1, 16'h1234, 4'd1, 4'd2, "preload");
    @(negedge clock);
    RegWrite = 1'b0; Read1 = 4'd1;
    #10 reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("async_rst_d3", Data3, 16'h0000);
    check_eq("async_rst_d1", Data1, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    // lacc sweep through the accumulator index
    for (int i = 0; i < 5; i++) cycle(1'b1, AccIdx, 16'(i), 4'd1, 4'd1, "lacc");

    cycle(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, "zero");
    cycle(1'b1, 4'd5, 16'hA5A5, 4'd5, 4'd9, "w5");
    cycle(1'b1, 4'd9, 16'h5A5A, 4'd5, 4'd9, "w9");
    cycle(1'b0, 4'd5, 16'hDEAD, 4'd5, 4'd9, "nowr");
    check_eq("dual_d1", Data1, 16'hA5A5);
    check_eq("dual_d2", Data2, 16'h5A5A);
    cycle(1'b1, 4'd3, 16'h0011, 4'd3, 4'd3, "w3");
    cycle(1'b1, 4'd3, 16'h0022, 4'd3, 4'd3, "rdw");

    // Reset asserted on the same edge as a write to the accumulator
    @(negedge clock);
    RegWrite = 1'b1; WriteReg = 4'd1; WriteData = 16'h7777; Read1 = 4'd5; Read2 = 4'd9;
    @(posedge clock);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("coll_d3", Data3, 16'h0000);
    check_eq("coll_d1", Data1, 16'h0000);
    check_eq("coll_d2", Data2, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    RegWrite = 1'b0;

    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
